// File: rtl/aludec_seq_pkg.sv
// aludec_seq_pkg: MIPS opcode/funct/rt/rs encodings, ALU control codes, HI/LO-class helpers
package aludec_seq_pkg;
    localparam int CTRL_W_DEF = 5;
    typedef logic [4:0] ctrl_t;
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_COP0   = 6'b010000;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_SRL     = 6'b000010;
    localparam logic [5:0] F_SRA     = 6'b000011;
    localparam logic [5:0] F_SLLV    = 6'b000100;
    localparam logic [5:0] F_SRLV    = 6'b000110;
    localparam logic [5:0] F_SRAV    = 6'b000111;
    localparam logic [5:0] F_JALR    = 6'b001001;
    localparam logic [5:0] F_SYSCALL = 6'b001100;
    localparam logic [5:0] F_BREAK   = 6'b001101;
    localparam logic [5:0] F_MFHI    = 6'b010000;
    localparam logic [5:0] F_MTHI    = 6'b010001;
    localparam logic [5:0] F_MFLO    = 6'b010010;
    localparam logic [5:0] F_MTLO    = 6'b010011;
    localparam logic [5:0] F_MULT    = 6'b011000;
    localparam logic [5:0] F_MULTU   = 6'b011001;
    localparam logic [5:0] F_DIV     = 6'b011010;
    localparam logic [5:0] F_DIVU    = 6'b011011;
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUB     = 6'b100010;
    localparam logic [5:0] F_SUBU    = 6'b100011;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_XOR     = 6'b100110;
    localparam logic [5:0] F_NOR     = 6'b100111;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SLTU    = 6'b101011;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;
    localparam logic [4:0] RS_MFC0   = 5'b00000;
    localparam logic [4:0] RS_MTC0   = 5'b00100;
    // Zero is reserved for "no ALU work" so legal no-op decodes and RI look alike on alucontrol.
    localparam ctrl_t NONE_CONTROL  = 5'd0;
    localparam ctrl_t AND_CONTROL   = 5'd1;
    localparam ctrl_t OR_CONTROL    = 5'd2;
    localparam ctrl_t XOR_CONTROL   = 5'd3;
    localparam ctrl_t NOR_CONTROL   = 5'd4;
    localparam ctrl_t LUI_CONTROL   = 5'd5;
    localparam ctrl_t SLL_CONTROL   = 5'd6;
    localparam ctrl_t SRL_CONTROL   = 5'd7;
    localparam ctrl_t SRA_CONTROL   = 5'd8;
    localparam ctrl_t SLLV_CONTROL  = 5'd9;
    localparam ctrl_t SRLV_CONTROL  = 5'd10;
    localparam ctrl_t SRAV_CONTROL  = 5'd11;
    localparam ctrl_t MFHI_CONTROL  = 5'd12;
    localparam ctrl_t MTHI_CONTROL  = 5'd13;
    localparam ctrl_t MFLO_CONTROL  = 5'd14;
    localparam ctrl_t MTLO_CONTROL  = 5'd15;
    localparam ctrl_t ADD_CONTROL   = 5'd16;
    localparam ctrl_t ADDU_CONTROL  = 5'd17;
    localparam ctrl_t SUB_CONTROL   = 5'd18;
    localparam ctrl_t SUBU_CONTROL  = 5'd19;
    localparam ctrl_t SLT_CONTROL   = 5'd20;
    localparam ctrl_t SLTU_CONTROL  = 5'd21;
    localparam ctrl_t MULT_CONTROL  = 5'd22;
    localparam ctrl_t MULTU_CONTROL = 5'd23;
    localparam ctrl_t DIV_CONTROL   = 5'd24;
    localparam ctrl_t DIVU_CONTROL  = 5'd25;
    localparam ctrl_t MFC0_CONTROL  = 5'd26;
    localparam ctrl_t MTC0_CONTROL  = 5'd27;
    function automatic logic is_div_funct(input logic [5:0] f);
        return f inside {F_DIV, F_DIVU};
    endfunction
    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return is_div_funct(f) || f inside {F_MULT, F_MULTU};
    endfunction
    function automatic logic is_hilo_funct(input logic [5:0] f);
        return is_muldiv_funct(f) || f inside {F_MFHI, F_MFLO, F_MTHI, F_MTLO};
    endfunction
endpackage

// File: rtl/aludec_seq_if.sv
// aludec_seq_if: ID -> decoder -> EX handshake bundle
//  master: pipeline side, drives in_valid/op/rs/rt/funct/flush/out_ready
//  slave : aludec_seq, drives in_ready/out_valid/alucontrol/ri/hilo_start/hilo_busy/hilo_done
interface aludec_seq_if import aludec_seq_pkg::*; #(parameter int CTRL_W = CTRL_W_DEF);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [5:0]        funct;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alucontrol;
    logic              ri;
    logic              hilo_start;
    logic              hilo_busy;
    logic              hilo_done;
    modport master (
        output in_valid, op, rs, rt, funct, flush, out_ready,
        input  in_ready, out_valid, alucontrol, ri, hilo_start, hilo_busy, hilo_done
    );
    modport slave (
        input  in_valid, op, rs, rt, funct, flush, out_ready,
        output in_ready, out_valid, alucontrol, ri, hilo_start, hilo_busy, hilo_done
    );
endinterface

// File: rtl/aludec_core.sv
// aludec_core: combinational MIPS ALU decoder
//  in : op, rs, rt, funct instruction fields
//  out: alucontrol, ri (reserved instruction), is_hilo, is_muldiv, is_div class flags
module aludec_core import aludec_seq_pkg::*; #(
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              ri,
    output logic              is_hilo,
    output logic              is_muldiv,
    output logic              is_div
);
    ctrl_t ctl;
    always_comb begin
        ctl = NONE_CONTROL;
        ri  = 1'b0;
        case (op)
            OP_RTYPE: case (funct)
                F_AND:              ctl = AND_CONTROL;
                F_OR:               ctl = OR_CONTROL;
                F_XOR:              ctl = XOR_CONTROL;
                F_NOR:              ctl = NOR_CONTROL;
                F_SLL:              ctl = SLL_CONTROL;
                F_SRL:              ctl = SRL_CONTROL;
                F_SRA:              ctl = SRA_CONTROL;
                F_SLLV:             ctl = SLLV_CONTROL;
                F_SRLV:             ctl = SRLV_CONTROL;
                F_SRAV:             ctl = SRAV_CONTROL;
                F_MFHI:             ctl = MFHI_CONTROL;
                F_MTHI:             ctl = MTHI_CONTROL;
                F_MFLO:             ctl = MFLO_CONTROL;
                F_MTLO:             ctl = MTLO_CONTROL;
                F_ADD:              ctl = ADD_CONTROL;
                F_ADDU, F_JALR:     ctl = ADDU_CONTROL;
                F_SUB:              ctl = SUB_CONTROL;
                F_SUBU:             ctl = SUBU_CONTROL;
                F_SLT:              ctl = SLT_CONTROL;
                F_SLTU:             ctl = SLTU_CONTROL;
                F_MULT:             ctl = MULT_CONTROL;
                F_MULTU:            ctl = MULTU_CONTROL;
                F_DIV:              ctl = DIV_CONTROL;
                F_DIVU:             ctl = DIVU_CONTROL;
                F_SYSCALL, F_BREAK: ctl = NONE_CONTROL;
                default:            ri  = 1'b1;
            endcase
            OP_REGIMM: case (rt)
                RT_BGEZAL, RT_BLTZAL: ctl = ADDU_CONTROL;
                RT_BGEZ, RT_BLTZ:     ctl = NONE_CONTROL;
                default:              ri  = 1'b1;
            endcase
            OP_COP0: case (rs)
                RS_MTC0: ctl = MTC0_CONTROL;
                RS_MFC0: ctl = MFC0_CONTROL;
                default: ri  = 1'b1;
            endcase
            OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctl = NONE_CONTROL;
            OP_JAL, OP_ADDIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:                    ctl = ADDU_CONTROL;
            OP_ADDI:                                ctl = ADD_CONTROL;
            OP_SLTI:                                ctl = SLT_CONTROL;
            OP_SLTIU:                               ctl = SLTU_CONTROL;
            OP_ANDI:                                ctl = AND_CONTROL;
            OP_ORI:                                 ctl = OR_CONTROL;
            OP_XORI:                                ctl = XOR_CONTROL;
            OP_LUI:                                 ctl = LUI_CONTROL;
            default:                                ri  = 1'b1;
        endcase
    end
    assign alucontrol = CTRL_W'(ctl);
    assign is_hilo    = (op == OP_RTYPE) && is_hilo_funct(funct);
    assign is_muldiv  = (op == OP_RTYPE) && is_muldiv_funct(funct);
    assign is_div     = (op == OP_RTYPE) && is_div_funct(funct);
endmodule

// File: rtl/aludec_seq.sv
// aludec_seq: registered, handshaked ALU decoder with HI/LO multi-cycle sequencer
//  clk, rst : clock, synchronous active-high reset
//  bus      : aludec_seq_if.slave (ID input handshake, EX output handshake, HI/LO status)
module aludec_seq import aludec_seq_pkg::*; #(
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input logic         clk,
    input logic         rst,
    aludec_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_ri;
    logic              dec_hilo;
    logic              dec_muldiv;
    logic              dec_div;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_ri;
    logic              out_muldiv;
    logic              out_div;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              issue;
    logic              in_ready;
    logic              accept;
    aludec_core #(.CTRL_W(CTRL_W)) u_core (
        .op        (bus.op),
        .rs        (bus.rs),
        .rt        (bus.rt),
        .funct     (bus.funct),
        .alucontrol(dec_ctrl),
        .ri        (dec_ri),
        .is_hilo   (dec_hilo),
        .is_muldiv (dec_muldiv),
        .is_div    (dec_div)
    );
    assign issue = out_valid && bus.out_ready && out_muldiv;
    // HI/LO-class input is also held back in the issue cycle itself: the unit becomes busy on
    // that edge, so a second MULT*/DIV* or an MF*/MT* must not slip into the register behind it.
    assign in_ready = (!out_valid || bus.out_ready) && !(dec_hilo && (state == S_BUSY || issue))
                      && !bus.flush;
    assign accept = bus.in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_ri     <= 1'b0;
            out_muldiv <= 1'b0;
            out_div    <= 1'b0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_ctrl   <= dec_ctrl;
            out_ri     <= dec_ri;
            out_muldiv <= dec_muldiv;
            out_div    <= dec_div;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (issue && state != S_BUSY) begin
            state <= S_BUSY;
            cnt   <= out_div ? DIV_LD : MUL_LD;
        end else if (state == S_BUSY) begin
            state <= (cnt == '0) ? S_DONE : S_BUSY;
            cnt   <= (cnt == '0) ? cnt : cnt - 1'b1;
        end else begin
            state <= S_IDLE;
        end
    end
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.alucontrol = out_ctrl;
    assign bus.ri         = out_ri;
    assign bus.hilo_start = issue;
    assign bus.hilo_busy  = (state == S_BUSY);
    assign bus.hilo_done  = (state == S_DONE);
endmodule

// File: tb/tb_aludec_seq.sv
// tb_aludec_seq: directed self-checking bench for aludec_seq
module tb_aludec_seq;
    import aludec_seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    aludec_seq_if bus ();
    aludec_seq dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] funct;
        logic [4:0] ctl;
        logic       ri;
    } vec_t;
    vec_t vecs[16];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic present(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [5:0] funct);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.funct    = funct;
    endtask
    always @(negedge clk)
        if (!rst) chk("issue_while_busy", 32'(bus.hilo_busy & bus.hilo_start), 32'd0);
    initial begin
        int busy_n;
        int done_n;
        int got;
        vecs[0]  = '{6'b111111, 5'd0,     5'd0,     6'b000000, NONE_CONTROL, 1'b1};
        vecs[1]  = '{6'b000000, 5'd0,     5'd0,     6'b001001, ADDU_CONTROL, 1'b0};
        vecs[2]  = '{6'b001100, 5'd0,     5'd0,     6'b000000, AND_CONTROL,  1'b0};
        vecs[3]  = '{6'b001111, 5'd0,     5'd0,     6'b000000, LUI_CONTROL,  1'b0};
        vecs[4]  = '{6'b101011, 5'd0,     5'd0,     6'b000000, ADDU_CONTROL, 1'b0};
        vecs[5]  = '{6'b000001, 5'd0,     5'b10001, 6'b000000, ADDU_CONTROL, 1'b0};
        vecs[6]  = '{6'b000001, 5'd0,     5'b00000, 6'b000000, NONE_CONTROL, 1'b0};
        vecs[7]  = '{6'b000001, 5'd0,     5'b00011, 6'b000000, NONE_CONTROL, 1'b1};
        vecs[8]  = '{6'b010000, 5'b00100, 5'd0,     6'b000000, MTC0_CONTROL, 1'b0};
        vecs[9]  = '{6'b010000, 5'b00001, 5'd0,     6'b000000, NONE_CONTROL, 1'b1};
        vecs[10] = '{6'b000000, 5'd0,     5'd0,     6'b111111, NONE_CONTROL, 1'b1};
        vecs[11] = '{6'b000000, 5'd0,     5'd0,     6'b001100, NONE_CONTROL, 1'b0};
        vecs[12] = '{6'b000000, 5'd0,     5'd0,     6'b000111, SRAV_CONTROL, 1'b0};
        vecs[13] = '{6'b000100, 5'd0,     5'd0,     6'b000000, NONE_CONTROL, 1'b0};
        vecs[14] = '{6'b001011, 5'd0,     5'd0,     6'b000000, SLTU_CONTROL, 1'b0};
        vecs[15] = '{6'b000000, 5'd0,     5'd0,     6'b100111, NOR_CONTROL,  1'b0};
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.funct     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alucontrol", 32'(bus.alucontrol), 32'd0);
        chk("rst_ri", 32'(bus.ri), 32'd0);
        chk("rst_hilo_start", 32'(bus.hilo_start), 32'd0);
        chk("rst_hilo_busy", 32'(bus.hilo_busy), 32'd0);
        chk("rst_hilo_done", 32'(bus.hilo_done), 32'd0);
        rst = 1'b0;
        present(6'b001001, 5'd0, 5'd0, 6'd0);
        #1 chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_ctrl", 32'(bus.alucontrol), 32'(ADDU_CONTROL));
        chk("t1_ri", 32'(bus.ri), 32'd0);
        tick();
        chk("t1_drain", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            present(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].funct);
            tick();
            chk($sformatf("dec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("dec%0d_ctrl", i), 32'(bus.alucontrol), 32'(vecs[i].ctl));
            chk($sformatf("dec%0d_ri", i), 32'(bus.ri), 32'(vecs[i].ri));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t2_drain", 32'(bus.out_valid), 32'd0);
        present(6'b000000, 5'd0, 5'd0, 6'b011010);
        tick();
        present(6'b000000, 5'd0, 5'd0, 6'b010010);
        #1;
        chk("t3_start", 32'(bus.hilo_start), 32'd1);
        chk("t3_block_at_issue", 32'(bus.in_ready), 32'd0);
        busy_n = 0;
        done_n = 0;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            busy_n += int'(bus.hilo_busy);
            done_n += int'(bus.hilo_done);
            if (bus.in_ready) begin
                got = 1;
                break;
            end
            chk("t3_stall_while_busy", 32'(bus.hilo_busy), 32'd1);
        end
        chk("t3_mflo_released", 32'(got), 32'd1);
        chk("t3_busy_cycles", 32'(busy_n), 32'd32);
        chk("t3_done_at_release", 32'(bus.hilo_done), 32'd1);
        chk("t3_done_pulses", 32'(done_n), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("t3_mflo_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_mflo_ctrl", 32'(bus.alucontrol), 32'(MFLO_CONTROL));
        chk("t3_done_cleared", 32'(bus.hilo_done), 32'd0);
        chk("t3_idle", 32'(bus.hilo_busy), 32'd0);
        tick();
        present(6'b000000, 5'd0, 5'd0, 6'b011000);
        tick();
        present(6'b000000, 5'd0, 5'd0, 6'b100001);
        #1;
        chk("t4_start", 32'(bus.hilo_start), 32'd1);
        chk("t4_addu_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t4_addu_ctrl", 32'(bus.alucontrol), 32'(ADDU_CONTROL));
        chk("t4_busy1", 32'(bus.hilo_busy), 32'd1);
        present(6'b000000, 5'd0, 5'd0, 6'b100100);
        #1 chk("t4_and_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t4_and_ctrl", 32'(bus.alucontrol), 32'(AND_CONTROL));
        chk("t4_busy2", 32'(bus.hilo_busy), 32'd1);
        chk("t4_not_done_yet", 32'(bus.hilo_done), 32'd0);
        present(6'b100011, 5'd0, 5'd0, 6'd0);
        #1 chk("t4_lw_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t4_lw_ctrl", 32'(bus.alucontrol), 32'(ADDU_CONTROL));
        chk("t4_lw_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_done", 32'(bus.hilo_done), 32'd1);
        chk("t4_busy_clear", 32'(bus.hilo_busy), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        chk("t4_done_once", 32'(bus.hilo_done), 32'd0);
        bus.out_ready = 1'b0;
        present(6'b000000, 5'd0, 5'd0, 6'b101010);
        tick();
        chk("t5_slt_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_slt_ctrl", 32'(bus.alucontrol), 32'(SLT_CONTROL));
        present(6'b000000, 5'd0, 5'd0, 6'b100000);
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_hold_ready", 32'(bus.in_ready), 32'd0);
            tick();
            chk("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t5_hold_ctrl", 32'(bus.alucontrol), 32'(SLT_CONTROL));
            chk("t5_hold_ri", 32'(bus.ri), 32'd0);
        end
        bus.flush = 1'b1;
        #1 chk("t5_flush_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_flushed", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("t5_no_accept", 32'(bus.out_valid), 32'd0);
        present(6'b000000, 5'd0, 5'd0, 6'b011010);
        tick();
        bus.in_valid = 1'b0;
        tick();
        repeat (9) tick();
        chk("t6_busy_before_rst", 32'(bus.hilo_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", 32'(bus.hilo_busy), 32'd0);
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_done", 32'(bus.hilo_done), 32'd0);
        chk("t6_ctrl", 32'(bus.alucontrol), 32'd0);
        done_n = 0;
        busy_n = 0;
        repeat (40) begin
            tick();
            done_n += int'(bus.hilo_done);
            busy_n += int'(bus.hilo_busy);
        end
        chk("t6_no_done", 32'(done_n), 32'd0);
        chk("t6_stays_idle", 32'(busy_n), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
